sp_mem_arbiter: RTL
===================

// Module: sp_mem_arbiter
// PURPOSE
// - N-channel round-robin arbiter merging processor memory requesters (imem, dmem, future DMA) onto one shared req/ack memory port.
// - Sits between the simple_processor core and a single-ported memory. Each channel speaks the core's req/wr/addr/wdata -> rdata/ack protocol.
// - One transaction in flight at a time. Request fields are registered, so mem side is stable regardless of channel behaviour.
// PARAMETERS
// - NUM_CH          2                    number of requester channels, >=1
// - ADDR_WIDTH      sp_pkg::ADDR_WIDTH   address bus width
// - DATA_WIDTH      sp_pkg::DATA_WIDTH   data bus width
// - TIMEOUT_CYCLES  256                  max ISSUE cycles before forced completion (timeout build only), >=2
// PORTS
// - clk_i          in   1                      single clock, all logic on rising edge
// - rst_i          in   1                      synchronous, active-high reset
// - ch_req_i       in   NUM_CH                 per-channel request
// - ch_wr_i        in   NUM_CH                 per-channel write (1) / read (0)
// - ch_addr_i      in   NUM_CH x ADDR_WIDTH    per-channel address
// - ch_wdata_i     in   NUM_CH x DATA_WIDTH    per-channel write data
// - ch_rdata_o     out  DATA_WIDTH             read data, shared, valid with ch_ack_o
// - ch_ack_o       out  NUM_CH                 one-hot completion pulse
// - mem_req_o      out  1                      shared memory request
// - mem_wr_o       out  1                      shared memory write strobe
// - mem_addr_o     out  ADDR_WIDTH             shared memory address
// - mem_wdata_o    out  DATA_WIDTH             shared memory write data
// - mem_rdata_i    in   DATA_WIDTH             memory read data, valid with mem_ack_i
// - mem_ack_i      in   1                      memory completion
// - busy_o         out  1                      high whenever state != IDLE
// - timeout_o      out  1                      pulses with ch_ack_o when a transaction timed out
// BEHAVIOUR
// - Reset (rst_i=1 at edge): state=IDLE, rr pointer=0, timeout counter=0. All outputs 0.
// - Reset mid-transaction: mem_req_o low the cycle after. Latched request dropped. No ch_ack_o is issued.
// - FSM IDLE -> ISSUE -> RESP -> IDLE.
// - IDLE: if any ch_req_i, grant the first requesting channel at or after rr pointer, wrapping modulo NUM_CH.
//   - Latch grant index, ch_wr_i, ch_addr_i and ch_wdata_i of the winner, then go to ISSUE.
// - ISSUE: mem_req_o=1 with the latched wr/addr/wdata, held constant.
//   - mem_ack_i is accepted in any ISSUE cycle, including the first.
//   - On ack: register mem_rdata_i into ch_rdata_o, set rr pointer = grant+1 mod NUM_CH, go to RESP.
// - RESP: ch_ack_o[grant]=1 for exactly one cycle, mem_req_o=0, then IDLE.
// - Latency: ch_req_i sampled at edge 0 -> mem_req_o high cycle 1. mem_ack_i at cycle k -> ch_ack_o high cycle k+1.
//   - Minimum 3 cycles per transaction. One IDLE cycle between back-to-back grants.
// - mem_ack_i outside ISSUE: ignored.
// - ch_rdata_o: holds its last value outside RESP. Updated on writes too, value unused.
// - Channel rule: hold req and fields until ack, drop req the cycle after ack. Early deassertion does not disturb mem side.
// - Fairness: a channel re-requesting immediately cannot win twice in a row while another channel requests.
// - NUM_CH=1: pointer and grant index are width-1 constants 0. Grant is always channel 0.
// CONFIGURATION
// - Macro SP_MEM_ARB_TIMEOUT_EN.
// - Defined:
//   - Counter clears on entering ISSUE and increments each ISSUE cycle.
//   - If no ack by ISSUE cycle TIMEOUT_CYCLES: drop mem_req_o and go to RESP with ch_rdata_o='0, timeout_o=1 alongside ch_ack_o.
//   - rr pointer advances as for a normal completion.
//   - Ack in the final allowed cycle wins: normal completion, timeout_o=0.
// - Undefined: no counter, timeout_o tied 0, ISSUE waits indefinitely for mem_ack_i.
// TESTING
// - Single read: ch0 req addr=0x10, mem acks cycle 1 with rdata=0xDEADBEEF -> mem_req_o cycles 1..1, ch_ack_o=2'b01 cycle 2, ch_rdata_o=0xDEADBEEF.
// - Contention: ch0 and ch1 both request continuously from reset, ack each ISSUE first cycle -> grants alternate ch0,ch1,ch0,ch1. ch_ack_o never two-hot.
// - Write: ch1 wr=1 addr=0x20 wdata=0x1234, mem ack after 5 cycles -> mem_wr_o=1, mem_addr_o=0x20, mem_wdata_o=0x1234 held stable all 5 cycles, ch_ack_o=2'b10 once.
// - Reset mid-ISSUE: rst_i=1 at ISSUE cycle 2 -> next cycle mem_req_o=0, busy_o=0, no ch_ack_o. Later ch1 request is granted first (pointer=0 and only ch1 requesting).
// - Stray ack: mem_ack_i=1 in IDLE with no requests -> no ch_ack_o, state stays IDLE.
// - Timeout (macro on, TIMEOUT_CYCLES=4): ch0 req, no mem ack -> mem_req_o high 4 cycles, then ch_ack_o=2'b01, timeout_o=1, ch_rdata_o=0.

Source files
------------

// File: rtl/sp_mem_arbiter_if.sv
// sp_mem_arbiter_if
// Bundles the per-channel requester buses and the shared memory port of
// sp_mem_arbiter. The arbiter connects through the slave modport; whatever
// drives the channels and models the memory uses the master modport.
interface sp_mem_arbiter_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  // Requester side: one req/wr/addr/wdata set per channel, shared rdata.
  logic [NUM_CH-1:0]                 ch_req_i;
  logic [NUM_CH-1:0]                 ch_wr_i;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr_i;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata_i;
  logic [DATA_WIDTH-1:0]             ch_rdata_o;
  logic [NUM_CH-1:0]                 ch_ack_o;

  // Shared single-ported memory side.
  logic                              mem_req_o;
  logic                              mem_wr_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic [DATA_WIDTH-1:0]             mem_wdata_o;
  logic [DATA_WIDTH-1:0]             mem_rdata_i;
  logic                              mem_ack_i;

  // Status.
  logic                              busy_o;
  logic                              timeout_o;

  // Arbiter view.
  modport slave (
    input  ch_req_i, ch_wr_i, ch_addr_i, ch_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output ch_rdata_o, ch_ack_o,
    output mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    output busy_o, timeout_o
  );

  // Environment view: requesters plus memory.
  modport master (
    output ch_req_i, ch_wr_i, ch_addr_i, ch_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  ch_rdata_o, ch_ack_o,
    input  mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    input  busy_o, timeout_o
  );

endinterface

// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter
// Round-robin arbiter that merges NUM_CH req/ack memory requesters (imem,
// dmem, later DMA) onto one shared single-ported memory port. Exactly one
// transaction is in flight; the winner's request fields are latched so the
// memory side stays stable no matter what the channel does afterwards.
//
// Flow: IDLE -> ISSUE -> RESP -> IDLE (minimum 3 cycles per transaction).
//
// Optional build macro: SP_MEM_ARB_TIMEOUT_EN
//   When defined, an ISSUE phase lasting TIMEOUT_CYCLES cycles without
//   mem_ack_i is force-completed: the channel receives its ack with zero
//   read data and timeout_o raised. When undefined, ISSUE waits forever
//   and timeout_o is tied low.
//
// ADDR_WIDTH / DATA_WIDTH defaults mirror the processor core's bus widths;
// override them from the core package at instantiation.
module sp_mem_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sp_mem_arbiter_if.slave bus
);

  // Grant index width; a single channel still gets a 1-bit (constant 0) index.
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Reject nonsensical configurations at elaboration time.
  if (NUM_CH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("sp_mem_arbiter: NUM_CH must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic [IDX_W-1:0]        rr_reg;        // first channel considered next time
  logic [IDX_W-1:0]        winner;        // combinational pick in IDLE
  logic [IDX_W-1:0]        grant_reg;     // channel owning the current transaction

  logic                    wr_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    tmo_flag_reg;  // current RESP is a forced completion

  logic                    any_req;
  logic                    start_issue;   // IDLE and someone is asking
  logic                    mem_done;      // memory acknowledged during ISSUE
  logic                    timed_out;     // ISSUE budget exhausted this cycle
  logic                    finish_issue;  // leaving ISSUE this cycle

  assign any_req      = |bus.ch_req_i;
  assign start_issue  = (state_reg == ST_IDLE) && any_req;
  assign mem_done     = (state_reg == ST_ISSUE) && bus.mem_ack_i;
  assign finish_issue = mem_done || timed_out;

  // ---------------------------------------------------------------------
  // Round-robin selection and pointer
  // ---------------------------------------------------------------------
  if (NUM_CH == 1) begin : g_single
    // Only one requester: grant and pointer are constant zero.
    assign winner = '0;
    assign rr_reg = '0;
  end else begin : g_multi
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] grant_inc;

    // Scan channels starting at the pointer, wrapping modulo NUM_CH; the
    // first requester found wins.
    always_comb begin
      winner = rr_reg;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cand = {1'b0, rr_reg} + SUM_W'(i);
        if (cand >= SUM_W'(NUM_CH)) begin
          cand = cand - SUM_W'(NUM_CH);
        end
        if (!found && bus.ch_req_i[cand[IDX_W-1:0]]) begin
          winner = cand[IDX_W-1:0];
          found  = 1'b1;
        end
      end
    end

    // Channel after the current grant, wrapping at NUM_CH-1.
    always_comb begin
      grant_inc = grant_reg + IDX_W'(1);
      if (grant_reg == IDX_W'(NUM_CH - 1)) begin
        grant_inc = '0;
      end
    end

    // Pointer moves past the served channel on every completion (normal or
    // forced), so a channel that re-requests at once cannot win twice in a
    // row while another channel is waiting.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_reg <= '0;
      end else if (finish_issue) begin
        rr_reg <= grant_inc;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional ISSUE timeout
  // ---------------------------------------------------------------------
`ifdef SP_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_reg;

  // Counts ISSUE cycles already spent; cleared on the way into ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_reg <= '0;
    end else if (start_issue) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
    end
  end

  // Fires in the last allowed ISSUE cycle only when no ack arrived, so an
  // ack in that final cycle still completes normally.
  assign timed_out = (state_reg == ST_ISSUE) && !bus.mem_ack_i &&
                     (tmo_cnt_reg == CNT_LAST);
`else
  assign timed_out = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: grant, wait for the memory, then one ack cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (finish_issue) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Latch the winner's request at grant time and capture the response on
  // completion; a reset discards any latched request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_reg    <= '0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      tmo_flag_reg <= 1'b0;
    end else begin
      if (start_issue) begin
        grant_reg    <= winner;
        wr_reg       <= bus.ch_wr_i[winner];
        addr_reg     <= bus.ch_addr_i[winner];
        wdata_reg    <= bus.ch_wdata_i[winner];
        tmo_flag_reg <= 1'b0;
      end
      if (mem_done) begin
        rdata_reg <= bus.mem_rdata_i;
      end else if (timed_out) begin
        rdata_reg    <= '0;
        tmo_flag_reg <= 1'b1;
      end
    end
  end

  // Memory port: request and write strobe only while issuing; address and
  // data come straight from the latched copy.
  assign bus.mem_req_o   = (state_reg == ST_ISSUE);
  assign bus.mem_wr_o    = (state_reg == ST_ISSUE) && wr_reg;
  assign bus.mem_addr_o  = addr_reg;
  assign bus.mem_wdata_o = wdata_reg;

  // Requester side: shared read data, one-hot ack during RESP.
  assign bus.ch_rdata_o = rdata_reg;
  assign bus.busy_o     = (state_reg != ST_IDLE);
  assign bus.timeout_o  = (state_reg == ST_RESP) && tmo_flag_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ack
    assign bus.ch_ack_o[gi] = (state_reg == ST_RESP) && (grant_reg == IDX_W'(gi));
  end

endmodule
